// File: rtl/systolic_result_reader_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic result reader slice:
//   SLICES_DEFAULT  default compute-slice count of the attached array
//   RESULT_COUNT    result bytes per readout for the default slice count
//   result_count()  derives the result byte count from a slice count
//   reader_state_t  readout FSM state encoding
// ---------------------------------------------------------------------------
package systolic_pkg;

  localparam int SLICES_DEFAULT = 4;

  // Each slice pair of the array yields two result bytes.
  function automatic int result_count(input int slices);
    return 2 * slices * slices;
  endfunction

  localparam int RESULT_COUNT = 2 * SLICES_DEFAULT * SLICES_DEFAULT;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } reader_state_t;

endpackage

// File: rtl/systolic_result_reader_if.sv
// ---------------------------------------------------------------------------
// systolic_result_reader_if
// Valid/ready result stream leaving the reader.
//   m_valid  result byte available
//   m_ready  consumer accepts the byte (transfer on m_valid && m_ready)
//   m_data   result byte
//   m_last   marks the final byte of a readout
// master: the reader side; slave: the consumer side.
// ---------------------------------------------------------------------------
interface systolic_result_reader_if;

  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/systolic_result_reader_result_buffer.sv
// ---------------------------------------------------------------------------
// result_buffer
// DEPTH x 8 register file holding one complete readout, one write port and
// one asynchronous read port. Storage is deliberately not reset; the reader
// masks the read data whenever the buffer is logically empty.
//   clk    clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data (combinational from storage)
// ---------------------------------------------------------------------------
module result_buffer
  import systolic_pkg::*;
#(
  parameter int DEPTH = RESULT_COUNT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Single write port; no reset so the storage maps onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/systolic_result_reader.sv
// ---------------------------------------------------------------------------
// systolic_result_reader
// Reads one batch of N result bytes out of a systolic array: pulses the
// array's readout strobe, captures the serial byte stream into a buffer
// without ever stalling it, and forwards the bytes in index order over a
// valid/ready stream while capture is still in progress.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   start      request one readout (only honoured in IDLE)
//   busy       high whenever the reader is not IDLE
//   readout_o  one-cycle strobe to the array (restart/clear/load out queue)
//   array_out  serial result byte from the array, one per cycle
//   m          result stream (systolic_result_reader_if.master)
//
// Configuration macro:
//   RESULT_RELU_EN  when defined, bytes with bit 7 set are stored as 0x00
// ---------------------------------------------------------------------------
module systolic_result_reader
  import systolic_pkg::*;
#(
  parameter int SLICES = SLICES_DEFAULT,
  parameter int N      = result_count(SLICES)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  output logic                            busy,
  output logic                            readout_o,
  input  logic [7:0]                      array_out,
  systolic_result_reader_if.master        m
);

  // Buffer addresses cover 0..N-1; pointers need one extra code for "full".
  localparam int AW = $clog2(N);
  localparam int PW = $clog2(N + 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);
  localparam logic [PW-1:0] FULL_IDX = PW'(N);

  reader_state_t state;
  reader_state_t next_state;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          has_data;
  logic          xfer;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic [7:0]    rd_data;

  assign has_data = (rd_ptr < wr_ptr);
  assign xfer     = has_data && m.m_ready;
  assign wr_en    = (state == CAPTURE) && (wr_ptr != FULL_IDX);

`ifdef RESULT_RELU_EN
  // Negative results (bit 7 set) are clamped to zero on the way in.
  assign wr_data = array_out[7] ? 8'h00 : array_out;
`else
  assign wr_data = array_out;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode. CAPTURE runs exactly N cycles because the array
  // stream cannot be paused; DRAIN ends with the transfer of the last byte.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = PULSE;
      PULSE:   next_state = CAPTURE;
      CAPTURE: if (wr_ptr == LAST_IDX) next_state = DRAIN;
      DRAIN:   if (xfer && (rd_ptr == LAST_IDX)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Write/read pointers. They only move forward within a readout and are
  // cleared together when the readout completes, so a fresh readout
  // always starts from an empty buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if ((state == DRAIN) && (next_state == IDLE)) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (xfer) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  result_buffer #(
    .DEPTH (N),
    .AW    (AW)
  ) u_buffer (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_data)
  );

  // All outputs are decoded from state and pointer registers. The data
  // output is masked while empty so unwritten storage never leaks out.
  assign busy      = (state != IDLE);
  assign readout_o = (state == PULSE);
  assign m.m_valid = has_data;
  assign m.m_data  = has_data ? rd_data : 8'h00;
  assign m.m_last  = has_data && (rd_ptr == LAST_IDX);

endmodule

// File: doc/systolic_result_reader.md
SYSTOLIC_RESULT_READER -- requirements
Module: systolic_result_reader

Interface
REQ-001 Parameter SLICES, default 4, compute-slice count of the attached systolic array.
REQ-002 Parameter N (derived), default 2*SLICES*SLICES = 32, result bytes per readout.
REQ-003 clk  input  1  the single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request one readout; sampled only in IDLE.
REQ-006 busy  output  1  high in every state other than IDLE.
REQ-007 readout_o  output  1  one-cycle pulse to the array: restart inputs, clear accumulators, load the out queue.
REQ-008 array_out  input  8  serial result byte from the array, one byte per cycle.
REQ-009 m_valid  output  1  result byte available.
REQ-010 m_ready  input  1  consumer accepts the byte; transfer when m_valid && m_ready.
REQ-011 m_data  output  8  result byte, index order 0..N-1.
REQ-012 m_last  output  1  high with m_valid when the byte is index N-1.

Function
REQ-013 FSM states IDLE, PULSE, CAPTURE, DRAIN; all outputs registered or decoded from registers only.
REQ-014 IDLE: start=1 at an edge -> PULSE; start=0 -> stay.
REQ-015 PULSE lasts exactly one cycle with readout_o=1, then -> CAPTURE; readout_o=0 in all other states.
REQ-016 CAPTURE lasts exactly N cycles; cycle k (0..N-1) writes array_out into buffer[k]; wr_ptr counts 0..N.
REQ-017 Capture never stalls; the array stream has no backpressure, so the buffer holds all N bytes.
REQ-018 m_valid = (rd_ptr < wr_ptr); reads proceed concurrently with CAPTURE.
REQ-019 m_data = buffer[rd_ptr]; rd_ptr increments on each transfer.
REQ-020 After the last CAPTURE cycle -> DRAIN; DRAIN -> IDLE on the edge completing transfer of index N-1.
REQ-021 Latency: start sampled at edge E0 -> readout_o high in cycle 1 -> array_out index 0 captured in cycle 2 -> m_valid earliest in cycle 3.
REQ-022 start while busy is ignored; no second readout_o pulse; no pointer change.
REQ-023 m_valid, once high, stays high with m_data stable until transferred.
REQ-024 Full: wr_ptr==N stops writes. Empty: rd_ptr==wr_ptr forces m_valid=0. Pointers never wrap within one readout; both clear on IDLE entry.
REQ-025 Byte values pass through unchanged, except under REQ-029.

Reset
REQ-026 rst_n low forces immediately: state=IDLE, wr_ptr=rd_ptr=0, busy=0, readout_o=0, m_valid=0, m_last=0, m_data=0.
REQ-027 Buffer contents need no reset; m_data reads 0 while rd_ptr==wr_ptr.
REQ-028 Reset in any state abandons the readout; the first start after release behaves as from power-up.

Configuration
REQ-029 Macro RESULT_RELU_EN: when defined, capture writes 0x00 for any array_out with bit 7 set. When undefined, bytes are stored verbatim. The macro changes no ports and no timing.

Structure
REQ-030 Shared package systolic_pkg holds SLICES_DEFAULT, the derived result count N and the FSM state enum.
REQ-031 One sub-module, result_buffer: N x 8 register file with one write port and one read port; no reset on storage.

Verification
REQ-032 start pulse; array model drives 0x00..0x1F in CAPTURE; m_ready=1 -> readout_o high 1 cycle; m_valid first in cycle 3; m_data 0x00..0x1F consecutive; m_last only on 0x1F; busy low next cycle.
REQ-033 m_ready=0 until CAPTURE ends, then 1 -> all 32 bytes delivered in order; none lost or duplicated.
REQ-034 start held high for 40 cycles -> exactly one readout_o pulse; after return to IDLE with start still high, a second readout begins.
REQ-035 rst_n low after 10 bytes captured -> all outputs 0 asynchronously; after release a new start yields a full 32-byte sequence.
REQ-036 m_ready toggling 1,0,1,0 -> order preserved; m_data stable while stalled; exactly one m_last.
REQ-037 RESULT_RELU_EN defined; stream 0x80,0xFF,0x7F,0x01 -> 0x00,0x00,0x7F,0x01. Undefined -> 0x80,0xFF,0x7F,0x01.
